// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//   Bundles the program-memory bus and the executor handshake used by the
//   instruction fetch sequencer.
//
//   Signals
//     mem_addr     program-memory address (driven by the fetch FSM, = pc)
//     mem_rd       one-cycle read strobe per fetch
//     mem_data     program-memory read data, valid MEM_LAT cycles after mem_rd
//     done         one-cycle pulse from the active executor: instruction complete
//     pcInc        one-cycle pulse from the active executor: advance PC
//     instruction  instruction register, stable for the whole EXEC state
//     IF_active    1 = fetch in progress, executors held in their reset state
//
//   Modports
//     master  the fetch FSM
//     slave   program memory plus the execute FSMs
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              done;
    logic              pcInc;
    logic [DATA_W-1:0] instruction;
    logic              IF_active;

    modport master (
        output mem_addr,
        output mem_rd,
        output instruction,
        output IF_active,
        input  mem_data,
        input  done,
        input  pcInc
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  instruction,
        input  IF_active,
        output mem_data,
        output done,
        output pcInc
    );
endinterface

// File: rtl/instr_fetch_fsm.sv
// -----------------------------------------------------------------------------
// instr_fetch_fsm
//   Fetch-side sequencer for the execute-stage FSMs. It holds the PC, reads an
//   instruction word from program memory, latches it into the IR, then releases
//   the executors (IF_active low) and waits for their done pulse. All PC
//   advance lives here, including the executors' pcInc requests, so the PC
//   moves by exactly one per instruction. An executor that never reports done
//   parks the sequencer in a sticky FAULT state until reset.
//
//   Ports
//     clk      rising-edge clock
//     rst      synchronous, active-high reset
//     run_i    1 = fetch/execute continuously, 0 = stop at next boundary
//     bus      instr_fetch_if.master (memory bus + executor handshake)
//     pc_o     program counter
//     fault_o  sticky executor-timeout flag
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | stopped; waits for run_i
//   ADDR  | mem_rd pulse, mem_addr = pc
//   WAIT  | memory latency, MEM_LAT-1 cycles
//   LATCH | mem_data valid; IR captured at the end of this cycle
//   EXEC  | executors released (IF_active = 0); waits for done
//   FAULT | executor timed out; terminal until rst
// -----------------------------------------------------------------------------
module instr_fetch_fsm #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    instr_fetch_if.master     bus,
    output logic [ADDR_W-1:0] pc_o,
    output logic              fault_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        LATCH = 3'd3,
        EXEC  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam int WW = $clog2(MEM_LAT + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    // Last WAIT cycle index; WAIT is skipped entirely when MEM_LAT is 1.
    localparam logic [WW-1:0] WAIT_LAST = WW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    // EXEC cycle index k runs from 0; after TIMEOUT cycles with no done we fault.
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TO_MAX    = CW'(TIMEOUT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic              mem_rd_q;
    logic              if_active_q;
    logic              fault_q;
    logic [WW-1:0]     wait_cnt_q;
    logic [CW-1:0]     exec_cnt_q;
    logic              inc_seen_q;
    logic              advance;
    logic              is_nop;

    assign is_nop = (bus.mem_data[DATA_W-1 -: 4] == 4'b0000);

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run_i) state_d = ADDR;
            end
            ADDR: begin
                state_d = (MEM_LAT > 1) ? WAIT : LATCH;
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) state_d = LATCH;
            end
            LATCH: begin
                if (is_nop) begin
                    advance = 1'b1;
                    state_d = run_i ? ADDR : IDLE;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // One +1 per instruction: the first pcInc, or done if no pcInc came.
                advance = !inc_seen_q && (bus.pcInc || bus.done);
                if (bus.done) begin
                    state_d = run_i ? ADDR : IDLE;
                end else if (exec_cnt_q == TO_LAST) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            mem_rd_q    <= 1'b0;
            if_active_q <= 1'b1;
            fault_q     <= 1'b0;
            wait_cnt_q  <= '0;
            exec_cnt_q  <= '0;
            inc_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Outputs are registered from the next state so they line up with it.
            mem_rd_q    <= (state_d == ADDR);
            if_active_q <= (state_d != EXEC);
            if (state_d == FAULT) fault_q <= 1'b1;

            if (advance) pc_q <= pc_q + ADDR_W'(1);
            if (state_q == LATCH) ir_q <= bus.mem_data;

            if (state_q == ADDR) begin
                wait_cnt_q <= '0;
            end else if (state_q == WAIT) begin
                wait_cnt_q <= wait_cnt_q + WW'(1);
            end

            if (state_q != EXEC) begin
                exec_cnt_q <= '0;
                inc_seen_q <= 1'b0;
            end else begin
                if (exec_cnt_q != TO_MAX) exec_cnt_q <= exec_cnt_q + CW'(1);
                if (bus.pcInc) inc_seen_q <= 1'b1;
            end
        end
    end

    assign bus.mem_addr    = pc_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.instruction = ir_q;
    assign bus.IF_active   = if_active_q;
    assign pc_o            = pc_q;
    assign fault_o         = fault_q;

endmodule

// File: tb/tb_instr_fetch_fsm.sv
module tb_instr_fetch_fsm;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              fault;

    int checks = 0;
    int errors = 0;

    instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    instr_fetch_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(2),
        .TIMEOUT(31)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .run_i  (run),
        .bus    (bus),
        .pc_o   (pc),
        .fault_o(fault)
    );

    always #5 clk = ~clk;

    // Program memory with a 2-cycle read latency; data is garbage when not valid.
    logic [DATA_W-1:0] mem [256];
    logic              rd_p1 = 1'b0, rd_p2 = 1'b0;
    logic [ADDR_W-1:0] a_p1 = '0, a_p2 = '0;
    always @(posedge clk) begin
        rd_p1 <= bus.mem_rd;
        a_p1  <= bus.mem_addr;
        rd_p2 <= rd_p1;
        a_p2  <= a_p1;
    end
    assign bus.mem_data = rd_p2 ? mem[a_p2] : 16'hDEAD;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'h0);
        check({tag, "_ir"}, 32'(bus.instruction), 32'h0);
        check({tag, "_rd"}, 32'(bus.mem_rd), 32'h0);
        check({tag, "_ifa"}, 32'(bus.IF_active), 32'h1);
        check({tag, "_fault"}, 32'(fault), 32'h0);
    endtask

    initial begin
        logic found;
        logic exec_seen;
        bus.done  = 1'b0;
        bus.pcInc = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h9042;
        mem[1] = 16'h1234;
        mem[2] = 16'h2000;
        mem[3] = 16'h3000;
        mem[4] = 16'h4000;
        mem[5] = 16'h5000;

        // Reset and idle
        tick(2);
        check_reset("rst0");
        rst = 1'b0;
        tick();
        check("idle_rd", 32'(bus.mem_rd), 32'h0);

        // Test 1: first fetch, MEM_LAT=2
        run = 1'b1;
        tick();                                     // c0 ADDR
        check("t1_c0_rd", 32'(bus.mem_rd), 32'h1);
        check("t1_c0_addr", 32'(bus.mem_addr), 32'h0);
        tick();                                     // c1 WAIT
        check("t1_c1_rd", 32'(bus.mem_rd), 32'h0);
        tick();                                     // c2 LATCH
        check("t1_c2_ifa", 32'(bus.IF_active), 32'h1);
        tick();                                     // c3 EXEC
        check("t1_c3_ir", 32'(bus.instruction), 32'h9042);
        check("t1_c3_ifa", 32'(bus.IF_active), 32'h0);

        // Test 2: pcInc at c4, done at c12
        tick();                                     // c4
        check("t2_c4_pc", 32'(pc), 32'h0);
        bus.pcInc = 1'b1;
        tick();                                     // c5
        bus.pcInc = 1'b0;
        check("t2_c5_pc", 32'(pc), 32'h1);
        tick(7);                                    // c12
        check("t2_c12_ifa", 32'(bus.IF_active), 32'h0);
        bus.done = 1'b1;
        tick();                                     // c13 ADDR
        bus.done = 1'b0;
        check("t2_c13_rd", 32'(bus.mem_rd), 32'h1);
        check("t2_c13_addr", 32'(bus.mem_addr), 32'h1);
        check("t2_c13_pc", 32'(pc), 32'h1);
        check("t2_c13_ifa", 32'(bus.IF_active), 32'h1);

        // Test 3a: two pcInc pulses then done
        tick(3);
        check("t3a_ir", 32'(bus.instruction), 32'h1234);
        check("t3a_ifa", 32'(bus.IF_active), 32'h0);
        bus.pcInc = 1'b1;
        tick();
        bus.pcInc = 1'b0;
        check("t3a_pc1", 32'(pc), 32'h2);
        tick();
        bus.pcInc = 1'b1;
        tick();
        bus.pcInc = 1'b0;
        check("t3a_pc2", 32'(pc), 32'h2);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("t3a_pc3", 32'(pc), 32'h2);
        check("t3a_rd", 32'(bus.mem_rd), 32'h1);
        check("t3a_addr", 32'(bus.mem_addr), 32'h2);

        // Test 3b: done with no pcInc
        tick(3);
        check("t3b_ir", 32'(bus.instruction), 32'h2000);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("t3b_pc", 32'(pc), 32'h3);
        check("t3b_rd", 32'(bus.mem_rd), 32'h1);

        // Test 3c: pcInc and done together
        tick(3);
        check("t3c_ir", 32'(bus.instruction), 32'h3000);
        bus.pcInc = 1'b1;
        bus.done  = 1'b1;
        tick();
        bus.pcInc = 1'b0;
        bus.done  = 1'b0;
        check("t3c_pc", 32'(pc), 32'h4);
        check("t3c_rd", 32'(bus.mem_rd), 32'h1);

        // Test 6: run dropped mid-EXEC
        tick(3);
        check("t6_ir", 32'(bus.instruction), 32'h4000);
        run = 1'b0;
        tick(2);
        check("t6_ifa_hold", 32'(bus.IF_active), 32'h0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("t6_pc", 32'(pc), 32'h5);
        check("t6_ifa_idle", 32'(bus.IF_active), 32'h1);
        for (int i = 0; i < 3; i++) begin
            check("t6_idle_rd", 32'(bus.mem_rd), 32'h0);
            tick();
        end
        run = 1'b1;
        tick();
        check("t6_resume_rd", 32'(bus.mem_rd), 32'h1);
        check("t6_resume_addr", 32'(bus.mem_addr), 32'h5);
        tick(3);
        check("t6_resume_ir", 32'(bus.instruction), 32'h5000);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("t6_pc6", 32'(pc), 32'h6);

        // Test 4: NOPs from 6 up to 8'hFF, then wrap to 0
        found     = 1'b0;
        exec_seen = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (!bus.IF_active) exec_seen = 1'b1;
            if (bus.mem_rd && bus.mem_addr == 8'hFF) found = 1'b1;
        end
        check("t4_reach_ff", 32'(found), 32'h1);
        check("t4_no_exec", 32'(exec_seen), 32'h0);
        tick(2);                                    // LATCH of NOP at FF
        check("t4_latch_ifa", 32'(bus.IF_active), 32'h1);
        tick();                                     // ADDR at wrapped pc
        check("t4_pc_wrap", 32'(pc), 32'h0);
        check("t4_rd", 32'(bus.mem_rd), 32'h1);
        check("t4_addr", 32'(bus.mem_addr), 32'h0);
        check("t4_ifa", 32'(bus.IF_active), 32'h1);
        check("t4_ir_nop", 32'(bus.instruction), 32'h0);

        // Test 5: EXEC with done held low -> FAULT after 31 EXEC cycles
        tick(3);                                    // e0
        check("t5_ir", 32'(bus.instruction), 32'h9042);
        check("t5_ifa_e0", 32'(bus.IF_active), 32'h0);
        tick(30);                                   // e30
        check("t5_e30_fault", 32'(fault), 32'h0);
        check("t5_e30_ifa", 32'(bus.IF_active), 32'h0);
        tick();                                     // FAULT
        check("t5_fault", 32'(fault), 32'h1);
        check("t5_fault_ifa", 32'(bus.IF_active), 32'h1);
        check("t5_fault_rd", 32'(bus.mem_rd), 32'h0);
        bus.pcInc = 1'b1;
        bus.done  = 1'b1;
        tick();
        bus.pcInc = 1'b0;
        bus.done  = 1'b0;
        tick(3);
        check("t5_sticky", 32'(fault), 32'h1);
        check("t5_sticky_pc", 32'(pc), 32'h0);
        check("t5_sticky_rd", 32'(bus.mem_rd), 32'h0);
        check("t5_sticky_ifa", 32'(bus.IF_active), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("t5_rst");

        // Reset mid-EXEC discards a pending pcInc
        tick();                                     // ADDR
        check("rx_rd", 32'(bus.mem_rd), 32'h1);
        tick(3);                                    // EXEC
        check("rx_ifa", 32'(bus.IF_active), 32'h0);
        bus.pcInc = 1'b1;
        rst       = 1'b1;
        tick();
        bus.pcInc = 1'b0;
        rst       = 1'b0;
        check_reset("rx_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
